// File: rtl/pp_bank_scheduler.sv
// rtl/pp_bank_scheduler.sv - two-bank ping-pong RAM sequencer between a bit stream and a downstream consumer
module pp_bank_scheduler #(
    parameter int BLOCK_LEN = 192,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              in_ready,
    output logic              wren_A,
    output logic              wren_B,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wrdata,
    output logic              rden_A,
    output logic              rden_B,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic              q_A,
    input  logic              q_B,
    output logic              out_valid,
    output logic              out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        bank_full
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_LEN - 1);

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_rd_bank_d;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [1:0]        r_full;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_drain_done;

    logic              w_wr_acc;
    logic              w_wr_wrap;
    logic              w_issue;
    logic              w_release;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;

    assign in_ready  = ~reset & ~r_full[r_wr_bank];
    assign w_wr_acc  = in_valid & in_ready;
    assign w_wr_wrap = w_wr_acc & (r_wr_cnt == LAST_ADDR);

    // r_drain_done blocks re-reading the bank between its last read and its release
    assign w_issue   = ~reset & r_full[r_rd_bank] & (~r_out_valid | out_ready) & ~r_drain_done;
    assign w_release = r_out_valid & out_ready & r_out_last;

    assign w_set = w_wr_wrap ? (2'b01 << r_wr_bank)   : 2'b00;
    assign w_clr = w_release ? (2'b01 << r_rd_bank_d) : 2'b00;

    assign wren_A    = w_wr_acc & ~r_wr_bank;
    assign wren_B    = w_wr_acc &  r_wr_bank;
    assign wraddr    = r_wr_cnt;
    assign wrdata    = in_data;
    assign rden_A    = w_issue & ~r_rd_bank;
    assign rden_B    = w_issue &  r_rd_bank;
    assign rdaddr    = r_rd_cnt;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_rd_bank_d ? q_B : q_A;
    assign bank_full = r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_bank_d  <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_full       <= 2'b00;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            assert (r_wr_cnt <= LAST_ADDR);
            assert (r_rd_cnt <= LAST_ADDR);

            if (w_wr_acc) begin
                if (w_wr_wrap) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            // set and clear never hit the same bank, so both apply
            r_full <= (r_full | w_set) & ~w_clr;

            if (w_issue) begin
                r_rd_bank_d <= r_rd_bank;
                if (r_rd_cnt == LAST_ADDR) begin
                    r_rd_cnt     <= '0;
                    r_drain_done <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end

            if (w_release) begin
                r_rd_bank    <= ~r_rd_bank;
                r_rd_cnt     <= '0;
                r_drain_done <= 1'b0;
            end

            r_out_valid <= w_issue | (r_out_valid & ~out_ready);
            if (w_issue)
                r_out_last <= (r_rd_cnt == LAST_ADDR);
            else if (out_ready)
                r_out_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pp_bank_scheduler.sv
// tb/tb_pp_bank_scheduler.sv - randomized scoreboard bench for pp_bank_scheduler
module tb_pp_bank_scheduler;
    localparam int BL = 192;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_data = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, wren_A, wren_B, wrdata, rden_A, rden_B;
    logic [AW-1:0] wraddr, rdaddr;
    logic          q_A = 1'b0;
    logic          q_B = 1'b0;
    logic          out_valid, out_data, out_last;
    logic [1:0]    bank_full;

    logic          mem_a [256];
    logic          mem_b [256];

    int total = 0;
    int bad = 0;
    bit exp_q[$];
    int wr_bits, rd_bits, wr_blocks, rd_blocks, cyc;
    bit prev_stall, prev_data, prev_last;
    int last_pulses, rden_seen, ready_drops, first_valid_cyc, last_wr_cyc;

    pp_bank_scheduler #(.BLOCK_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wren_A(wren_A), .wren_B(wren_B), .wraddr(wraddr), .wrdata(wrdata),
        .rden_A(rden_A), .rden_B(rden_B), .rdaddr(rdaddr), .q_A(q_A), .q_B(q_B),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    // RAM pair: 1-cycle read latency, output held while rden is low
    always @(posedge clk) begin
        if (wren_A) mem_a[wraddr] <= wrdata;
        if (wren_B) mem_b[wraddr] <= wrdata;
        if (rden_A) q_A <= mem_a[rdaddr];
        if (rden_B) q_B <= mem_b[rdaddr];
    end

    task automatic model_clear();
        exp_q.delete();
        wr_bits = 0; rd_bits = 0; wr_blocks = 0; rd_blocks = 0; cyc = 0;
        prev_stall = 0; prev_data = 0; prev_last = 0;
        last_pulses = 0; rden_seen = 0; ready_drops = 0;
        first_valid_cyc = -1; last_wr_cyc = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic cycle(input bit iv, input bit id, input bit ordy, output bit acc);
        bit exp_rdy, exp_last, e;
        in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        exp_rdy = (wr_blocks - rd_blocks) < 2;
        total++;
        if (in_ready !== exp_rdy) begin
            bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
        end
        acc = iv && (in_ready === 1'b1);
        if (iv && !acc) ready_drops++;
        total++;
        if ({wren_B, wren_A} !== {acc && (wr_blocks % 2 == 1), acc && (wr_blocks % 2 == 0)}) begin
            bad++; $display("FAIL wren cyc=%0d got=%b%b exp_bank=%0d acc=%b", cyc, wren_B, wren_A, wr_blocks % 2, acc);
        end
        if (acc) begin
            total++;
            if (wraddr !== AW'(wr_bits % BL) || wrdata !== id) begin
                bad++; $display("FAIL wraddr cyc=%0d got=%0d/%b exp=%0d/%b", cyc, wraddr, wrdata, wr_bits % BL, id);
            end
        end
        if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b%b%b exp=1%b%b", cyc, out_valid, out_data, out_last, prev_data, prev_last);
            end
        end
        if (out_valid && !ordy) begin
            total++;
            if ((rden_A | rden_B) !== 1'b0) begin
                bad++; $display("FAIL stall_rden cyc=%0d got=%b%b exp=00", cyc, rden_B, rden_A);
            end
        end
        if (rden_A | rden_B) rden_seen++;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && ordy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL spurious_out cyc=%0d got=out_valid exp=empty", cyc);
            end else begin
                e = exp_q.pop_front();
                exp_last = (rd_bits % BL) == BL - 1;
                if (out_data !== e || out_last !== exp_last) begin
                    bad++; $display("FAIL out_bit n=%0d got=%b/%b exp=%b/%b", rd_bits, out_data, out_last, e, exp_last);
                end
                rd_bits++;
                if (rd_bits % BL == 0) rd_blocks++;
            end
            if (out_last) last_pulses++;
        end
        prev_stall = out_valid && !ordy;
        prev_data = out_data; prev_last = out_last;
        if (acc) begin
            exp_q.push_back(id);
            wr_bits++;
            if (wr_bits % BL == 0) begin
                wr_blocks++; last_wr_cyc = cyc;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n, target;
        bit a;
        target = (wr_bits / BL) * BL;
        n = 0;
        while (rd_bits < target && n < budget) begin
            cycle(1'b0, 1'b0, 1'b1, a);
            n++;
        end
        total++;
        if (rd_bits != target) begin
            bad++; $display("FAIL drain_timeout got=%0d exp=%0d", rd_bits, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({wren_A, wren_B, rden_A, rden_B, out_valid, out_last, bank_full, in_ready} !== 9'b0) begin
            bad++; $display("FAIL reset_state got=%b exp=0", {wren_A, wren_B, rden_A, rden_B, out_valid, out_last, bank_full, in_ready});
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || bank_full !== 2'b00) begin
            bad++; $display("FAIL reset_release got=%b/%b exp=1/00", in_ready, bank_full);
        end
        @(posedge clk); #1;
        model_clear();
    endtask

    task automatic test_single_block();
        bit a;
        for (int i = 0; i < BL; i++) cycle(1'b1, (i % 3) == 0, 1'b1, a);
        total++;
        if (bank_full !== 2'b01) begin
            bad++; $display("FAIL single_full got=%b exp=01", bank_full);
        end
        drain(1000);
        total++;
        if (first_valid_cyc - last_wr_cyc != 2) begin
            bad++; $display("FAIL latency got=%0d exp=2", first_valid_cyc - last_wr_cyc);
        end
        total++;
        if (last_pulses != 1 || bank_full !== 2'b00) begin
            bad++; $display("FAIL single_end got=%0d/%b exp=1/00", last_pulses, bank_full);
        end
    endtask

    task automatic test_stream();
        int n, guard;
        bit a, d;
        apply_reset();
        n = 0; guard = 0; d = 1'($urandom);
        while (n < 3 * BL && guard < 2000) begin
            cycle(1'b1, d, 1'b1, a);
            if (a) begin n++; d = 1'($urandom); end
            guard++;
        end
        drain(1000);
        total++;
        if (last_pulses != 3 || rd_bits != 3 * BL) begin
            bad++; $display("FAIL stream got=%0d/%0d exp=3/%0d", last_pulses, rd_bits, 3 * BL);
        end
        total++;
        if (ready_drops > 1) begin
            bad++; $display("FAIL stream_drops got=%0d exp<=1", ready_drops);
        end
    endtask

    task automatic test_stall_and_resume();
        int first_drop, n, guard;
        bit a, d;
        apply_reset();
        first_drop = -1; d = 1'($urandom);
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, d, 1'b0, a);
            if (a) d = 1'($urandom);
            else if (first_drop < 0) first_drop = i;
        end
        total++;
        if (first_drop != 2 * BL || wr_bits != 2 * BL || bank_full !== 2'b11) begin
            bad++; $display("FAIL stall_fill got=%0d/%0d/%b exp=%0d/%0d/11", first_drop, wr_bits, bank_full, 2 * BL, 2 * BL);
        end
        total++;
        if (rden_seen != 1) begin
            bad++; $display("FAIL stall_rden_count got=%0d exp=1", rden_seen);
        end
        n = 0; guard = 0;
        while (n < 16 && guard < 2000) begin
            cycle(1'b1, d, 1'b1, a);
            if (a) begin n++; d = 1'($urandom); end
            guard++;
        end
        total++;
        if (n != 16 || rd_blocks != 1) begin
            bad++; $display("FAIL resume got=%0d/%0d exp=16/1", n, rd_blocks);
        end
        drain(1000);
    endtask

    task automatic test_random();
        int guard;
        bit a, d, iv;
        apply_reset();
        guard = 0; d = 1'($urandom);
        while (wr_bits < 10 * BL && guard < 20000) begin
            iv = ($urandom_range(0, 3) != 0);
            cycle(iv, d, 1'($urandom_range(0, 1)), a);
            if (a) d = 1'($urandom);
            guard++;
        end
        drain(2000);
        total++;
        if (rd_bits != 10 * BL || last_pulses != 10) begin
            bad++; $display("FAIL random got=%0d/%0d exp=%0d/10", rd_bits, last_pulses, 10 * BL);
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        apply_reset();
        for (int i = 0; i < BL + 50; i++) cycle(1'b1, 1'($urandom), 1'b0, a);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'($urandom), 1'b1, a);
        total++;
        if (wraddr !== AW'(100) || bank_full !== 2'b01) begin
            bad++; $display("FAIL mid_setup got=%0d/%b exp=100/01", wraddr, bank_full);
        end
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_last, bank_full, wren_A, wren_B, rden_A, rden_B} !== 8'b0) begin
            bad++; $display("FAIL mid_reset got=%b exp=0", {out_valid, out_last, bank_full, wren_A, wren_B, rden_A, rden_B});
        end
        reset = 1'b0; in_valid = 1'b0;
        model_clear();
        for (int i = 0; i < BL; i++) cycle(1'b1, 1'($urandom), 1'b1, a);
        drain(1000);
        total++;
        if (last_pulses != 1 || bank_full !== 2'b00) begin
            bad++; $display("FAIL mid_fresh got=%0d/%b exp=1/00", last_pulses, bank_full);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_block();
        test_stream();
        test_stall_and_resume();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
